// File: rtl/preg_freelist.sv
// Circular free list of physical register IDs for rename: compacted multi-port
// allocation from head, compacted multi-port return at tail.
module preg_freelist #(
  parameter  int PREG_NUM     = 64,
  parameter  int FETCH_WIDTH  = 2,
  parameter  int COMMIT_WIDTH = 2,
  localparam int PW           = $clog2(PREG_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [FETCH_WIDTH-1:0]    alloc_req,
  output logic                      alloc_ready,
  input  logic                      alloc_fire,
  output logic [FETCH_WIDTH*PW-1:0] alloc_preg,
  input  logic [COMMIT_WIDTH-1:0]   free_valid,
  input  logic [COMMIT_WIDTH*PW-1:0] free_preg,
  output logic [PW:0]               free_count
);

  logic [PW-1:0] mem [PREG_NUM];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [PW:0]   nalloc;
  logic [PW:0]   nfree;
  logic [PW-1:0] waddr [COMMIT_WIDTH];
  logic          fire_ok;
  logic [PW+1:0] count_next_wide;

  // Allocation: slot i reads the entry k(i) past head, k(i) = requests below i.
  always_comb begin
    logic [PW:0]   acc;
    logic [PW-1:0] ridx;
    acc        = '0;
    ridx       = '0;
    alloc_preg = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      ridx = head + acc[PW-1:0];
      alloc_preg[i*PW +: PW] = mem[ridx];
      acc = acc + {{PW{1'b0}}, alloc_req[i]};
    end
    nalloc = acc;
  end

  // Free: valid slots are packed onto consecutive entries starting at tail.
  always_comb begin
    logic [PW:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      waddr[i] = tail + acc[PW-1:0];
      acc = acc + {{PW{1'b0}}, free_valid[i]};
    end
    nfree = acc;
  end

  assign alloc_ready = (count >= nalloc);
  assign free_count  = count;
  assign fire_ok     = alloc_fire && alloc_ready;

  always_comb begin
    count_next_wide = {1'b0, count} + {1'b0, nfree};
    if (fire_ok) count_next_wide = count_next_wide - {1'b0, nalloc};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < PREG_NUM; i++) mem[i] <= PW'(i);
      head  <= '0;
      tail  <= '0;
      count <= (PW+1)'(PREG_NUM);
    end else begin
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++)
        if (free_valid[i]) mem[waddr[i]] <= free_preg[i*PW +: PW];
      if (fire_ok) head <= head + nalloc[PW-1:0];
      tail  <= tail + nfree[PW-1:0];
      count <= count_next_wide[PW:0];
    end
  end

  a_fire_needs_ready : assert property (@(posedge clk) disable iff (reset || flush)
    alloc_fire |-> alloc_ready);

  a_no_double_free : assert property (@(posedge clk) disable iff (reset || flush)
    (!count_next_wide[PW+1] && (count_next_wide <= (PW+2)'(PREG_NUM))));

endmodule

// File: doc/preg_freelist.md
# preg_freelist

Circular free list of physical register IDs for the rename stage. Each cycle it hands up to FETCH_WIDTH free physical registers to renaming instructions; these become the new mappings written into the alias table. It takes back up to COMMIT_WIDTH IDs per cycle from retire. It sits beside the alias table in rename: its `alloc_preg` outputs drive the alias table's new-mapping inputs, and retire drives its free port.

## Interface

- `PREG_NUM`, default 64: number of physical registers. Must be a power of two.
- `FETCH_WIDTH`, default 2: allocation ports.
- `COMMIT_WIDTH`, default 2: free ports.
- `PW`, derived, equals $clog2(PREG_NUM): physical register ID width.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  pipeline flush; makes all physical registers free
- `alloc_req`  in  FETCH_WIDTH  per slot: instruction is valid and has dst != 0
- `alloc_ready`  out  1  every asserted request in this cycle can be granted
- `alloc_fire`  in  1  rename advances this cycle; only legal when alloc_ready is 1
- `alloc_preg`  out  FETCH_WIDTH×PW  ID offered to each slot
- `free_valid`  in  COMMIT_WIDTH  per retire slot: return an ID
- `free_preg`  in  COMMIT_WIDTH×PW  ID being returned
- `free_count`  out  PW+1  number of IDs currently free

## Operation

- State:
  - `mem[PREG_NUM]` of PW bits.
  - `head` and `tail`, PW bits each; both wrap naturally modulo PREG_NUM.
  - `count`, PW+1 bits; `free_count` equals `count`.
- Reset and flush, same effect:
  - `mem[i]=i`, `head=0`, `tail=0`, `count=PREG_NUM`.
  - Flush overrides any alloc_fire or free_valid in the same cycle; those are dropped.
- Allocation is compacted:
  - Let k(i) be the number of asserted `alloc_req[j]` with j<i.
  - `alloc_preg[i] = mem[head + k(i)]`.
  - For a slot with `alloc_req[i]=0`, alloc_preg[i] is don't-care; the bench must not check it.
- `nalloc` is the popcount of `alloc_req`.
- `alloc_ready = (count >= nalloc)`. All-or-nothing: there are no partial grants.
- On `alloc_fire && !flush`: `head <= head + nalloc`.
  - alloc_fire with nalloc=0 changes nothing.
  - alloc_fire while alloc_ready=0 is a protocol violation. The simulation assertion fires and state is not updated.
- Free is compacted in slot order:
  - Let m(i) be the number of asserted `free_valid[j]` with j<i.
  - `mem[tail + m(i)] <= free_preg[i]`.
  - `tail <= tail + nfree`.
- Count update, same cycle: `count <= count - (fire ? nalloc : 0) + nfree`.
- Simultaneous alloc and free in one cycle:
  - Legal.
  - IDs freed this cycle are not visible to allocation until the next cycle, because alloc_ready and alloc_preg use registered state only.
- Overflow: `count - nalloc + nfree > PREG_NUM` indicates a double free. The assertion fires and the behaviour is undefined.
- Freeing ID 0 is permitted. The block has no knowledge of architectural mappings.

## Timing

- `alloc_ready`, `alloc_preg` and `free_count` are combinational from registered state and `alloc_req`. There is no path from `free_*` or `flush` to them.
- Grant-to-update latency: 1 cycle. The next group of IDs appears at alloc_preg in the cycle after the fire.
- Freed ID: allocatable at the earliest 1 cycle after free_valid. When it is actually handed out depends on FIFO order.
- Reset values:
  - `free_count=PREG_NUM`.
  - `alloc_ready=1`.
  - `alloc_preg[0]=0`, `alloc_preg[1]=1` when both requests are asserted.
- Flush or reset mid-operation: all state listed above is restored on the same edge. The outputs in the following cycle equal the reset values.
- Wrap-around: head and tail pass through PREG_NUM-1 to 0 with no bubble. `count` alone tells empty from full (head==tail in both cases).

## Test plan

- Reset, then `alloc_req=2'b11` with fire for 3 cycles → alloc_preg pairs (0,1), (2,3), (4,5); free_count goes 64→62→60→58.
- Compaction: after reset, `alloc_req=2'b10` with fire → alloc_preg[1]=0; next cycle `2'b11` → (1,2); free_count=61.
- Exhaustion: allocate 63 IDs, then `alloc_req=2'b11` → alloc_ready=0 and free_count=1. With `2'b01` → alloc_ready=1 and alloc_preg[0]=63. After firing, free_count=0 and any request gives alloc_ready=0.
- Simultaneous: at free_count=0, free 7 and 9 (`free_valid=2'b11`) while `alloc_req=2'b01` is asserted → alloc_ready=0 that cycle. Next cycle free_count=2 and alloc_preg[0]=7, then alloc_preg[0]=9.
- Wrap: cycle all 64 IDs through alloc/free twice, freeing in reverse order → alloc order after the wrap matches the free order exactly; free_count never exceeds 64.
- Flush mid-stream: with free_count=40 and alloc_fire plus free_valid=2'b11 in the same cycle as flush=1 → next cycle free_count=64, alloc_preg=(0,1), and the frees are dropped.
